// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, the bubble
// word and the fetch FSM state encoding.
package if_stage_pkg;

    localparam int unsigned INST_BUS_W      = 32;
    localparam int unsigned INST_ADDR_BUS_W = 32;

    localparam logic [INST_BUS_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

    function automatic logic [INST_ADDR_BUS_W-1:0] word_align(
        input logic [INST_ADDR_BUS_W-1:0] a
    );
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding buffer for a fetched word and its PC+4 while decode stalls.
module if_skid_buf
    import if_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic                       unload,
    input  logic                       clear,
    input  logic [INST_BUS_W-1:0]      in_data,
    input  logic [INST_ADDR_BUS_W-1:0] in_addr,
    output logic [INST_BUS_W-1:0]      out_data,
    output logic [INST_ADDR_BUS_W-1:0] out_addr,
    output logic                       out_valid
);

    logic [INST_BUS_W-1:0]      data_d, data_q;
    logic [INST_ADDR_BUS_W-1:0] addr_d, addr_q;
    logic                       valid_d, valid_q;

    // Clear wins over load so a redirect always empties the entry.
    always_comb begin
        data_d  = data_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        if (clear || unload) begin
            data_d  = ZERO_WORD;
            addr_d  = ZERO_WORD;
            valid_d = 1'b0;
        end
        if (load && !clear) begin
            data_d  = in_data;
            addr_d  = in_addr;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= ZERO_WORD;
            addr_q  <= ZERO_WORD;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_addr  = addr_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single outstanding imem request, redirect handling
// with response dropping, and a one-entry buffer to absorb decode stalls.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [INST_ADDR_BUS_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall,
    input  logic                       redirect_valid,
    input  logic [INST_ADDR_BUS_W-1:0] redirect_addr,
    output logic                       imem_req,
    output logic [INST_ADDR_BUS_W-1:0] imem_addr,
    input  logic                       imem_ack,
    input  logic [INST_BUS_W-1:0]      imem_rdata,
    output logic [INST_BUS_W-1:0]      inst,
    output logic [INST_ADDR_BUS_W-1:0] inst_addr,
    output logic                       inst_valid
);

    localparam logic [INST_ADDR_BUS_W-1:0] RST_PC = word_align(RESET_PC);

    fetch_state_e               state_d, state_q;
    logic [INST_ADDR_BUS_W-1:0] pc_d, pc_q, pc_inc, target;
    logic                       imem_req_d, imem_req_q;
    logic [INST_ADDR_BUS_W-1:0] imem_addr_d, imem_addr_q;
    logic [INST_BUS_W-1:0]      inst_d, inst_q;
    logic [INST_ADDR_BUS_W-1:0] inst_addr_d, inst_addr_q;
    logic                       inst_valid_d, inst_valid_q;
    logic                       buf_load, buf_unload, buf_clear;
    logic [INST_BUS_W-1:0]      buf_data;
    logic [INST_ADDR_BUS_W-1:0] buf_addr;
    logic                       buf_valid;

    always_comb begin
        pc_inc       = pc_q + 32'd4;
        target       = word_align(redirect_addr);
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_addr_d  = inst_addr_q;
        inst_valid_d = inst_valid_q;
        buf_load     = 1'b0;
        buf_unload   = 1'b0;
        buf_clear    = 1'b0;

        // Redirect overrides stall and ack: bubble out, drop any buffered word.
        if (redirect_valid) begin
            pc_d         = target;
            inst_d       = ZERO_WORD;
            inst_addr_d  = ZERO_WORD;
            inst_valid_d = 1'b0;
            buf_clear    = 1'b1;
        end

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (redirect_valid) begin
                    state_d = imem_ack ? S_REQ : S_DROP;
                end else if (imem_ack) begin
                    pc_d = pc_inc;
                    if (stall) begin
                        buf_load = 1'b1;
                        state_d  = S_HOLD;
                    end else begin
                        inst_d       = imem_rdata;
                        inst_addr_d  = pc_inc;
                        inst_valid_d = 1'b1;
                    end
                end else if (!stall) begin
                    inst_d       = ZERO_WORD;
                    inst_addr_d  = ZERO_WORD;
                    inst_valid_d = 1'b0;
                end
            end
            S_DROP: begin
                if (imem_ack) state_d = S_REQ;
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    state_d = S_REQ;
                end else if (!stall) begin
                    inst_d       = buf_data;
                    inst_addr_d  = buf_addr;
                    inst_valid_d = buf_valid;
                    buf_unload   = 1'b1;
                    state_d      = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The stale request keeps its address until the memory acknowledges it.
        imem_req_d  = (state_d == S_REQ) || (state_d == S_DROP);
        imem_addr_d = (state_d == S_DROP) ? imem_addr_q : pc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RST_PC;
            imem_req_q   <= 1'b0;
            imem_addr_q  <= RST_PC;
            inst_q       <= ZERO_WORD;
            inst_addr_q  <= ZERO_WORD;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            imem_req_q   <= imem_req_d;
            imem_addr_q  <= imem_addr_d;
            inst_q       <= inst_d;
            inst_addr_q  <= inst_addr_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    if_skid_buf u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (buf_load),
        .unload    (buf_unload),
        .clear     (buf_clear),
        .in_data   (imem_rdata),
        .in_addr   (pc_inc),
        .out_data  (buf_data),
        .out_addr  (buf_addr),
        .out_valid (buf_valid)
    );

    assign imem_req   = imem_req_q;
    assign imem_addr  = imem_addr_q;
    assign inst       = inst_q;
    assign inst_addr  = inst_addr_q;
    assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a latency-programmable memory model feeds a scoreboard of
// expected (word, pc+4) pairs that a monitor retires as decode takes them.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        inst_valid;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst           (inst),
        .inst_addr      (inst_addr),
        .inst_valid     (inst_valid)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] addr;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_exp;
    int          n_cmp = 0;
    int          n_err = 0;

    logic [31:0] exp_pc = 32'h0;
    logic [31:0] drop_addr = 32'h0;
    logic [31:0] mem_want;
    bit          drop_pending = 1'b0;
    bit          mem_ack_now;
    bit          mem_en = 1'b0;
    bit          man_ack = 1'b0;
    logic [31:0] man_rdata = 32'h0;
    int          lat = 0;
    int          wait_cnt = 0;
    logic        mon_stall;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'd3) ^ 32'h1234_5678;
    endfunction

    // Memory model: acts just after the falling edge so this cycle's inputs are settled.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            wait_cnt     = 0;
            drop_pending = 1'b0;
            exp_pc       = 32'h0;
            sb.delete();
        end
        if (!mem_en) begin
            imem_ack   = man_ack;
            imem_rdata = man_rdata;
        end else if (!rst_n) begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
        end else begin
            imem_ack    = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
            mem_ack_now = 1'b0;
            if (imem_req) begin
                mem_want = drop_pending ? drop_addr : exp_pc;
                n_cmp++;
                if (imem_addr !== mem_want) begin
                    n_err++;
                    $display("FAIL imem_addr: got %h want %h", imem_addr, mem_want);
                end
                if (wait_cnt >= lat) begin
                    mem_ack_now = 1'b1;
                    wait_cnt    = 0;
                    imem_ack    = 1'b1;
                    imem_rdata  = word_of(imem_addr);
                end else begin
                    wait_cnt++;
                end
            end
            if (redirect_valid) begin
                if (mem_ack_now) begin
                    drop_pending = 1'b0;
                end else if (imem_req && !drop_pending) begin
                    drop_pending = 1'b1;
                    drop_addr    = exp_pc;
                end
                exp_pc = redirect_addr & ~32'h3;
            end else if (mem_ack_now) begin
                if (drop_pending) begin
                    drop_pending = 1'b0;
                end else begin
                    sb.push_back({word_of(exp_pc), exp_pc + 32'd4});
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end
    end

    // A new instruction reaches decode at any edge where stall was low.
    always @(posedge clk) begin
        mon_stall = stall;
        #2;
        if (rst_n && inst_valid && !mon_stall) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got inst_addr %h inst %h, want no instruction", inst_addr, inst);
            end else begin
                mon_exp = sb.pop_front();
                if (inst !== mon_exp.data || inst_addr !== mon_exp.addr) begin
                    n_err++;
                    $display("FAIL sb_inst: got %h@%h want %h@%h", inst, inst_addr, mon_exp.data, mon_exp.addr);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL reset_req: got req=%b addr=%h want req=0 addr=0", imem_req, imem_addr);
        end
        n_cmp++;
        if (inst !== 32'h0 || inst_addr !== 32'h0 || inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out: got inst=%h addr=%h v=%b want 0/0/0", inst, inst_addr, inst_valid);
        end
    endtask

    task automatic test_zero_wait();
        mem_en = 1'b1;
        lat    = 0;
        do_reset();
        @(posedge clk); #1;
        n_cmp++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL zw_first_req: got v=%b req=%b addr=%h want 0/1/0", inst_valid, imem_req, imem_addr);
        end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (inst_valid !== 1'b1 || inst_addr !== 32'(4 * k)) begin
                n_err++;
                $display("FAIL zw_seq: got v=%b addr=%h want 1/%h", inst_valid, inst_addr, 32'(4 * k));
            end
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic test_wait_states();
        int  gap = 0;
        int  nvalid = 0;
        bit  seen = 1'b0;
        mem_en = 1'b1;
        lat    = 2;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (inst_valid === 1'b1) begin
                if (seen) begin
                    n_cmp++;
                    if (gap != 2) begin
                        n_err++;
                        $display("FAIL ws_gap: got %0d bubbles want 2", gap);
                    end
                end
                seen = 1'b1;
                gap  = 0;
                nvalid++;
            end else begin
                gap++;
            end
        end
        n_cmp++;
        if (nvalid != 6) begin
            n_err++;
            $display("FAIL ws_count: got %0d instructions want 6", nvalid);
        end
    endtask

    task automatic test_stall_hold();
        mem_en = 1'b1;
        lat    = 0;
        do_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++;
        if (inst_addr !== 32'h4) begin
            n_err++;
            $display("FAIL st_pre: got %h want 00000004", inst_addr);
        end
        @(negedge clk);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (inst_addr !== 32'h4 || inst !== word_of(32'h0) || inst_valid !== 1'b1 || imem_req !== 1'b0) begin
                n_err++;
                $display("FAIL st_frozen: got %h@%h v=%b req=%b want %h@00000004 v=1 req=0",
                         inst, inst_addr, inst_valid, imem_req, word_of(32'h0));
            end
        end
        @(negedge clk);
        stall = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (inst_addr !== 32'h8 || inst !== word_of(32'h4) || inst_valid !== 1'b1) begin
            n_err++;
            $display("FAIL st_release: got %h@%h v=%b want %h@00000008", inst, inst_addr, inst_valid, word_of(32'h4));
        end
        @(posedge clk); #1;
        n_cmp++;
        if (inst_addr !== 32'hC || inst_valid !== 1'b1) begin
            n_err++;
            $display("FAIL st_resume: got %h v=%b want 0000000c", inst_addr, inst_valid);
        end
    endtask

    task automatic test_redirect_drop();
        bit found = 1'b0;
        mem_en = 1'b1;
        lat    = 2;
        do_reset();
        @(posedge clk);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0103;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk); #1;
            if (inst_valid === 1'b1) begin
                n_cmp++;
                n_err++;
                $display("FAIL drop_leak: got inst_addr %h want bubble", inst_addr);
            end
            if (imem_req === 1'b1 && imem_addr === 32'h100) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL drop_newaddr: got %h want 00000100", imem_addr);
        end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk); #1;
            if (inst_valid === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found || inst_addr !== 32'h104 || inst !== word_of(32'h100)) begin
            n_err++;
            $display("FAIL drop_first: got %h@%h v=%b want %h@00000104", inst, inst_addr, inst_valid, word_of(32'h100));
        end
    endtask

    task automatic test_redirect_ack_stall();
        mem_en = 1'b1;
        lat    = 0;
        do_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0200;
        @(posedge clk); #1;
        n_cmp++;
        if (inst_valid !== 1'b0 || inst !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            n_err++;
            $display("FAIL ras_bubble: got v=%b inst=%h req=%b addr=%h want 0/0/1/00000200",
                     inst_valid, inst, imem_req, imem_addr);
        end
        @(negedge clk);
        stall          = 1'b0;
        redirect_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (inst_valid !== 1'b1 || inst_addr !== 32'h204 || inst !== word_of(32'h200)) begin
            n_err++;
            $display("FAIL ras_target: got %h@%h v=%b want %h@00000204", inst, inst_addr, inst_valid, word_of(32'h200));
        end
    endtask

    task automatic test_wrap();
        mem_en = 1'b1;
        lat    = 0;
        do_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_addr  = 32'hFFFF_FFF8;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (inst_addr !== 32'hFFFF_FFFC || inst_valid !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_top: got %h v=%b want fffffffc", inst_addr, inst_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (inst_addr !== 32'h0 || inst_valid !== 1'b1 || imem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_zero: got inst_addr=%h v=%b imem_addr=%h want 0/1/0", inst_addr, inst_valid, imem_addr);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        mem_en  = 1'b0;
        man_ack = 1'b0;
        do_reset();
        @(posedge clk); #1;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL rm_req: got req=%b addr=%h want 1/0", imem_req, imem_addr);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_addr !== 32'h0 || imem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL rm_async: got req=%b v=%b inst=%h ia=%h addr=%h want all 0",
                     imem_req, inst_valid, inst, inst_addr, imem_addr);
        end
        @(negedge clk);
        man_ack   = 1'b1;
        man_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (inst_valid !== 1'b0 || inst !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL rm_late_ack: got v=%b inst=%h req=%b addr=%h want 0/0/1/0",
                     inst_valid, inst, imem_req, imem_addr);
        end
        @(negedge clk);
        man_ack = 1'b0;
        mem_en  = 1'b1;
        lat     = 0;
        @(posedge clk); #1;
        n_cmp++;
        if (inst_valid !== 1'b1 || inst_addr !== 32'h4 || inst !== word_of(32'h0)) begin
            n_err++;
            $display("FAIL rm_first: got %h@%h v=%b want %h@00000004", inst, inst_addr, inst_valid, word_of(32'h0));
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_hold();
        test_redirect_drop();
        test_redirect_ack_stall();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, fetch address after reset.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: stall  input  1  hazard unit: decode must keep its current instruction.
REQ-005 Port: redirect_valid  input  1  decode resolved a taken jump/branch this cycle.
REQ-006 Port: redirect_addr  input  32  new fetch target.
REQ-007 Port: imem_req  output  1  instruction-memory request.
REQ-008 Port: imem_addr  output  32  request address, word aligned.
REQ-009 Port: imem_ack  input  1  memory returns data this cycle; may coincide with imem_req.
REQ-010 Port: imem_rdata  input  32  instruction word, valid only while imem_ack=1.
REQ-011 Port: inst  output  32  registered instruction to decode; ZeroWord when not valid.
REQ-012 Port: inst_addr  output  32  registered fetch PC+4 of inst (decode's branch/link base).
REQ-013 Port: inst_valid  output  1  inst is a real instruction, not a bubble.

Function
REQ-014 States: S_IDLE, S_REQ (one request outstanding), S_DROP (outstanding response to be discarded), S_HOLD (fetched word buffered during stall).
REQ-015 At most one request outstanding; imem_req and imem_addr stay constant from assertion until the acknowledging cycle.
REQ-016 S_IDLE -> S_REQ unconditionally one cycle after reset release; imem_req=1 in S_REQ and S_DROP only.
REQ-017 S_REQ, ack, stall=0, no redirect: inst<=imem_rdata, inst_addr<=pc+4, inst_valid<=1, pc<=pc+4; stay S_REQ with new address next cycle (one instruction per cycle with zero-wait memory).
REQ-018 S_REQ, ack, stall=1, no redirect: word and pc+4 go into 1-entry buffer, pc<=pc+4, -> S_HOLD; outputs unchanged.
REQ-019 S_REQ, no ack, stall=0: output bubble (inst_valid<=0, inst<=ZeroWord); with stall=1 outputs hold.
REQ-020 S_HOLD, stall=0: buffer moves to output, buffer emptied, -> S_REQ; with stall=1 hold everything, imem_req=0.
REQ-021 Redirect has priority over stall and ack; target low 2 bits forced to 0; pc<=target; output becomes bubble next edge; buffer emptied.
REQ-022 Redirect in S_REQ without ack -> S_DROP (address may not change mid-request); S_DROP on ack discards data -> S_REQ at pc.
REQ-023 Redirect in S_REQ with ack same cycle: data discarded, -> S_REQ with target next cycle.
REQ-024 Redirect in S_DROP: pc overwritten with newest target, remain S_DROP.
REQ-025 Redirect in S_HOLD: buffered word discarded, -> S_REQ with target.
REQ-026 pc arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0, no flag.

Reset
REQ-027 rst_n low asynchronously forces: pc=RESET_PC, state=S_IDLE, imem_req=0, imem_addr=RESET_PC, inst=ZeroWord, inst_addr=ZeroWord, inst_valid=0, buffer empty.
REQ-028 Reset mid-request abandons it; any ack arriving in S_IDLE is ignored.

Structure
REQ-029 State encodings, ZeroWord, InstBus, InstAddrBus widths live in the shared macros definitions file.
REQ-030 The one-entry buffer is a sub-module if_skid_buf (data+addr+valid, load/unload/clear).

Verification
REQ-031 Reset, ack same cycle every cycle -> inst_addr sequence 4,8,12; inst_valid=1 from 2nd cycle after release.
REQ-032 Ack 3 cycles after req, stall=0 -> exactly 2 bubbles between instructions, imem_addr stable while waiting.
REQ-033 Ack arriving with stall=1 for 4 cycles -> outputs frozen, imem_req=0; stall release -> buffered word appears next edge.
REQ-034 Redirect to 32'h0000_0103 in S_REQ without ack -> S_DROP, returning word never at output, next imem_addr=32'h0000_0100.
REQ-035 Redirect and ack same cycle with stall=1 -> bubble next cycle, imem_addr=target, no buffered word.
REQ-036 rst_n low during outstanding request, late ack -> outputs stay reset values, first fetch at RESET_PC.
